// File: rtl/apb_master_pkg.sv
// Shared constants for the APB4 master: state encodings, protection width
// and an elaboration-time clog2 helper.
package apb_master_pkg;

  localparam int APB_PROT_W = 3;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/apb_addr_decode.sv
// Slave-index decode: extracts the slave field from the byte address and
// flags whether it names an existing slave.
module apb_addr_decode
  import apb_master_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int NUM_SLAVES = 4,
  parameter int SLV_LSB    = 12,
  localparam int SEL_W     = (clog2(NUM_SLAVES) > 1) ? clog2(NUM_SLAVES) : 1
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [SEL_W-1:0]  idx,
  output logic              hit
);

  logic unused_addr;

  assign idx         = addr[SLV_LSB +: SEL_W];
  assign hit         = ({1'b0, idx} < (SEL_W + 1)'(NUM_SLAVES));
  assign unused_addr = ^addr;

endmodule

// File: rtl/apb_master_ctrl.sv
// APB4 master: one request at a time, SETUP/ACCESS transfer to a decoded
// slave, registered response. Define APB_MASTER_TIMEOUT_EN to bound ACCESS.
module apb_master_ctrl
  import apb_master_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int NUM_SLAVES     = 4,
  parameter int SLV_LSB        = 12,
  parameter int TIMEOUT_CYCLES = 255,
  localparam int SEL_W         = (clog2(NUM_SLAVES) > 1) ? clog2(NUM_SLAVES) : 1,
  localparam int STRB_W        = DATA_W / 8
) (
  input  logic                         PCLK,
  input  logic                         PRESETn,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_write,
  input  logic [ADDR_W-1:0]            req_addr,
  input  logic [DATA_W-1:0]            req_wdata,
  input  logic [STRB_W-1:0]            req_strb,
  input  logic [APB_PROT_W-1:0]        req_prot,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [DATA_W-1:0]            rsp_rdata,
  output logic                         rsp_err,
  output logic [ADDR_W-1:0]            PADDR,
  output logic [APB_PROT_W-1:0]        PPROT,
  output logic [NUM_SLAVES-1:0]        PSEL,
  output logic                         PENABLE,
  output logic                         PWRITE,
  output logic [DATA_W-1:0]            PWDATA,
  output logic [STRB_W-1:0]            PSTRB,
  input  logic [NUM_SLAVES-1:0]        PREADY,
  input  logic [NUM_SLAVES*DATA_W-1:0] PRDATA,
  input  logic [NUM_SLAVES-1:0]        PSLVERR,
  output logic [1:0]                   state_o
);

  logic [1:0]            state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [STRB_W-1:0]     strb_q, strb_d;
  logic [APB_PROT_W-1:0] prot_q, prot_d;
  logic                  write_q, write_d;
  logic [SEL_W-1:0]      idx_q, idx_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic [SEL_W-1:0]      dec_idx;
  logic                  dec_hit;
  logic                  sel_ready;
  logic                  sel_err;
  logic [DATA_W-1:0]     sel_rdata;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CNT_W = (clog2(TIMEOUT_CYCLES + 1) > 1) ? clog2(TIMEOUT_CYCLES + 1) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

  apb_addr_decode #(
    .ADDR_W     (ADDR_W),
    .NUM_SLAVES (NUM_SLAVES),
    .SLV_LSB    (SLV_LSB)
  ) u_decode (
    .addr (req_addr),
    .idx  (dec_idx),
    .hit  (dec_hit)
  );

  // Only the captured slave's inputs are looked at; all others are ignored.
  always_comb begin
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (idx_q == SEL_W'(i)) begin
        sel_ready = PREADY[i];
        sel_err   = PSLVERR[i];
        sel_rdata = PRDATA[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    prot_d  = prot_q;
    write_d = write_q;
    idx_d   = idx_q;
    rdata_d = rdata_q;
    err_d   = err_q;
`ifdef APB_MASTER_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          write_d = req_write;
          wdata_d = req_write ? req_wdata : '0;
          strb_d  = req_write ? req_strb : '0;
          prot_d  = req_prot;
          idx_d   = dec_hit ? dec_idx : '0;
          rdata_d = '0;
          err_d   = ~dec_hit;
          state_d = dec_hit ? ST_SETUP : ST_RESP;
        end
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      ST_ACCESS: begin
        if (sel_ready) begin
          rdata_d = (!write_q && !sel_err) ? sel_rdata : '0;
          err_d   = sel_err;
          state_d = ST_RESP;
        end
`ifdef APB_MASTER_TIMEOUT_EN
        // Compare against the pre-increment value so ACCESS lasts exactly TIMEOUT_CYCLES.
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      default: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      prot_q  <= '0;
      write_q <= 1'b0;
      idx_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      prot_q  <= prot_d;
      write_q <= write_d;
      idx_q   <= idx_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
`ifdef APB_MASTER_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  always_comb begin
    PSEL = '0;
    if (state_q == ST_SETUP || state_q == ST_ACCESS) begin
      for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
        if (idx_q == SEL_W'(i)) PSEL[i] = 1'b1;
      end
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign PENABLE   = (state_q == ST_ACCESS);
  assign PADDR     = addr_q;
  assign PPROT     = prot_q;
  assign PWRITE    = write_q;
  assign PWDATA    = wdata_q;
  assign PSTRB     = strb_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Self-checking bench for apb_master_ctrl: per-transaction timeline model
// with a per-cycle compare process, directed corner cases and random traffic.
module tb_apb_master_ctrl;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int NS  = 3;
  localparam int LSB = 12;
  localparam int TO  = 4;
`ifdef APB_MASTER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          PRESETn;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [3:0]    req_strb;
  logic [2:0]    req_prot;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] PADDR;
  logic [2:0]    PPROT;
  logic [NS-1:0] PSEL;
  logic          PENABLE, PWRITE;
  logic [DW-1:0] PWDATA;
  logic [3:0]    PSTRB;
  logic [NS-1:0] PREADY, PSLVERR;
  logic [NS*DW-1:0] PRDATA;
  logic [1:0]    state_o;

  apb_master_ctrl #(
    .ADDR_W         (AW),
    .DATA_W         (DW),
    .NUM_SLAVES     (NS),
    .SLV_LSB        (LSB),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .PCLK      (clk),
    .PRESETn   (PRESETn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_strb  (req_strb),
    .req_prot  (req_prot),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .PADDR     (PADDR),
    .PPROT     (PPROT),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PWDATA    (PWDATA),
    .PSTRB     (PSTRB),
    .PREADY    (PREADY),
    .PRDATA    (PRDATA),
    .PSLVERR   (PSLVERR),
    .state_o   (state_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // Expected per-cycle view of the DUT, written by the stimulus timeline.
  logic          chk_en = 1'b0;
  logic [1:0]    e_state;
  logic          e_rreq, e_rv, e_pen, e_bus;
  logic [NS-1:0] e_psel;
  logic [AW-1:0] e_paddr;
  logic          e_pwrite;
  logic [2:0]    e_pprot;
  logic [DW-1:0] e_pwdata, e_rdata;
  logic [3:0]    e_pstrb;
  logic          e_err;

  always @(negedge clk) begin
    if (chk_en && PRESETn) begin
      chk("state", 32'(state_o), 32'(e_state));
      chk("req_ready", 32'(req_ready), 32'(e_rreq));
      chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
      chk("psel", 32'(PSEL), 32'(e_psel));
      chk("penable", 32'(PENABLE), 32'(e_pen));
      if (e_bus) begin
        chk("paddr", PADDR, e_paddr);
        chk("pwrite", 32'(PWRITE), 32'(e_pwrite));
        chk("pprot", 32'(PPROT), 32'(e_pprot));
        chk("pwdata", PWDATA, e_pwdata);
        chk("pstrb", 32'(PSTRB), 32'(e_pstrb));
      end
      if (e_rv) begin
        chk("rsp_rdata", rsp_rdata, e_rdata);
        chk("rsp_err", 32'(rsp_err), 32'(e_err));
      end
    end
  end

  // Observations used by the hand-computed literal expectations.
  logic [NS-1:0] psel_or;
  logic          rv_seen;
  int            rv_cyc, acc_cyc;
  logic [DW-1:0] got_rdata;
  logic          got_err;

  always @(negedge clk) begin
    psel_or = psel_or | PSEL;
    if (rsp_valid && !rv_seen) begin
      rv_seen   = 1'b1;
      rv_cyc    = cyc;
      got_rdata = rsp_rdata;
      got_err   = rsp_err;
    end
  end

  task automatic set_exp(input logic [1:0] st, input logic rr, input logic rv,
                         input logic [NS-1:0] ps, input logic pen, input logic bus);
    e_state = st; e_rreq = rr; e_rv = rv; e_psel = ps; e_pen = pen; e_bus = bus;
  endtask

  task automatic rand_apb();
    for (int i = 0; i < NS; i++) begin
      PREADY[i]  = 1'($urandom);
      PSLVERR[i] = 1'($urandom);
      PRDATA[i*DW +: DW] = $urandom;
    end
  endtask

  task automatic junk_req(input logic v);
    req_valid = v;
    req_write = 1'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_strb  = 4'($urandom);
    req_prot  = 3'($urandom);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      set_exp(2'd0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
      junk_req(1'b0);
      rsp_ready = 1'($urandom);
      rand_apb();
      @(posedge clk); #1;
    end
  endtask

  // Called at posedge+1 of an idle cycle; returns at posedge+1 of the next idle cycle.
  // rst_at >= 0 pulls reset in that ACCESS cycle and returns with reset held.
  task automatic txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] strb, input logic [2:0] prot, input int waits,
                     input logic slverr, input logic [31:0] rd, input int rdelay,
                     input int rst_at);
    int idx, acc_n;
    logic hit, to;
    idx   = int'((addr >> LSB) & 32'h3);
    hit   = (idx < NS);
    to    = TO_EN && hit && (waits >= TO);
    acc_n = to ? TO : waits + 1;
    e_err   = !hit || to || slverr;
    e_rdata = (hit && !to && !wr && !slverr) ? rd : 32'h0;
    e_paddr = addr; e_pwrite = wr; e_pprot = prot;
    e_pwdata = wr ? wdata : 32'h0;
    e_pstrb  = wr ? strb : 4'h0;
    psel_or = '0; rv_seen = 1'b0;

    set_exp(2'd0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
    req_strb = strb; req_prot = prot; rsp_ready = 1'($urandom);
    rand_apb();
    @(posedge clk); #1;
    acc_cyc = cyc;

    if (hit) begin
      set_exp(2'd1, 1'b0, 1'b0, NS'(1) << idx, 1'b0, 1'b1);
      junk_req(1'($urandom)); rand_apb();
      @(posedge clk); #1;
      for (int k = 0; k < acc_n; k++) begin
        set_exp(2'd2, 1'b0, 1'b0, NS'(1) << idx, 1'b1, 1'b1);
        junk_req(1'($urandom)); rand_apb();
        PREADY[idx] = (k == waits);
        if (k == waits) begin
          PSLVERR[idx] = slverr;
          PRDATA[idx*DW +: DW] = rd;
        end
        if (k == rst_at) begin
          chk_en = 1'b0;
          #2 PRESETn = 1'b0;
          #1;
          chk("rst_async_psel", 32'(PSEL), 32'h0);
          chk("rst_async_penable", 32'(PENABLE), 32'h0);
          chk("rst_async_rsp_valid", 32'(rsp_valid), 32'h0);
          chk("rst_async_req_ready", 32'(req_ready), 32'h1);
          return;
        end
        @(posedge clk); #1;
      end
    end

    for (int k = 0; k <= rdelay; k++) begin
      set_exp(2'd3, 1'b0, 1'b1, '0, 1'b0, 1'b0);
      junk_req(1'($urandom)); rand_apb();
      rsp_ready = (k == rdelay);
      @(posedge clk); #1;
    end
    set_exp(2'd0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    junk_req(1'b0);
  endtask

  initial begin
    logic [31:0] a;
    PRESETn = 1'b0; rsp_ready = 1'b0; junk_req(1'b0); rand_apb();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'h1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_err", 32'(rsp_err), 32'h0);
    chk("rst_psel", 32'(PSEL), 32'h0);
    chk("rst_penable", 32'(PENABLE), 32'h0);
    chk("rst_paddr", PADDR, 32'h0);
    chk("rst_pwdata", PWDATA, 32'h0);
    chk("rst_pstrb_pprot_pwrite", {25'h0, PSTRB, PPROT}, {31'h0, PWRITE});
    chk("rst_state", 32'(state_o), 32'h0);
    PRESETn = 1'b1;
    set_exp(2'd0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    chk_en = 1'b1;
    idle(2);

    // zero-wait write to slave 1
    txn(1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 4'hF, 3'd2, 0, 1'b0, 32'h0, 0, -1);
    chk("wr_psel", 32'(psel_or), 32'h2);
    chk("wr_latency", 32'(rv_cyc - acc_cyc + 1), 32'd3);
    chk("wr_rdata", got_rdata, 32'h0);
    chk("wr_err", 32'(got_err), 32'h0);

    // read with three wait states from slave 2
    txn(1'b0, 32'h0000_2008, 32'hFFFF_FFFF, 4'hF, 3'd5, 3, 1'b0, 32'h1234_5678, 0, -1);
    chk("rd_psel", 32'(psel_or), 32'h4);
    chk("rd_latency", 32'(rv_cyc - acc_cyc + 1), 32'd6);
    chk("rd_rdata", got_rdata, 32'h1234_5678);

    // PSLVERR with response back-pressure
    txn(1'b1, 32'h0000_0040, 32'hA5A5_5A5A, 4'h3, 3'd1, 1, 1'b1, 32'h0, 5, -1);
    chk("slverr_err", 32'(got_err), 32'h1);

    // decode error: slave field 3 with three slaves
    txn(1'b0, 32'h0000_3000, 32'h0, 4'h0, 3'd0, 0, 1'b0, 32'h0, 1, -1);
    chk("dec_psel", 32'(psel_or), 32'h0);
    chk("dec_latency", 32'(rv_cyc - acc_cyc + 1), 32'd1);
    chk("dec_err", 32'(got_err), 32'h1);

    // long ACCESS: timeout when enabled, otherwise the wait continues
    txn(1'b0, 32'h0000_0010, 32'h0, 4'h0, 3'd0, 100, 1'b0, 32'hCAFE_0001, 0, -1);
    if (TO_EN) begin
      chk("to_latency", 32'(rv_cyc - acc_cyc + 1), 32'd6);
      chk("to_err", 32'(got_err), 32'h1);
    end else begin
      chk("noto_latency", 32'(rv_cyc - acc_cyc + 1), 32'd103);
      chk("noto_rdata", got_rdata, 32'hCAFE_0001);
    end
    txn(1'b0, 32'h0000_1000, 32'h0, 4'h0, 3'd0, TO - 1, 1'b0, 32'h0BAD_F00D, 0, -1);
    chk("to_edge_rdata", got_rdata, 32'h0BAD_F00D);
    txn(1'b1, 32'h0000_2000, 32'h1111_2222, 4'h5, 3'd3, TO, 1'b0, 32'h0, 0, -1);

    // reset during ACCESS
    txn(1'b0, 32'h0000_1000, 32'h0, 4'h0, 3'd0, 50, 1'b0, 32'h0, 0, 1);
    repeat (2) @(posedge clk);
    #1;
    PRESETn = 1'b1;
    set_exp(2'd0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    chk_en = 1'b1;
    idle(3);
    txn(1'b1, 32'h0000_2004, 32'h0102_0304, 4'h9, 3'd7, 0, 1'b0, 32'h0, 0, -1);
    chk("post_rst_latency", 32'(rv_cyc - acc_cyc + 1), 32'd3);
    chk("post_rst_err", 32'(got_err), 32'h0);

    for (int n = 0; n < 80; n++) begin
      a = $urandom;
      txn(1'($urandom), a, $urandom, 4'($urandom), 3'($urandom),
          ($urandom_range(0, 7) == 0) ? int'($urandom_range(3, 6)) : int'($urandom_range(0, 2)),
          ($urandom_range(0, 3) == 0), $urandom, int'($urandom_range(0, 3)), -1);
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
    end

    idle(2);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
